stream_packer: RTL

- Width upsizer that sits directly upstream of the team's 32-bit FIFO.
- Accepts narrow beats (default 8-bit) on a valid/ready stream and packs RATIO beats into one wide word.
- Emits each wide word with per-lane keep bits and a last flag on a valid/ready stream that drives the FIFO write port.
- Handles packet ends and explicit flushes by emitting zero-filled partial words.

---
 rtl/stream_packer_pkg.sv | 18 +
 rtl/stream_reg_slice.sv | 45 ++++
 rtl/stream_packer.sv | 114 +++++++++++
 3 files changed

// File: rtl/stream_packer_pkg.sv
// Shared stream constants and helpers for the packer and the 32-bit FIFO.
// The packer and FIFO both take their default widths from here, so their
// DATA_WIDTH values stay in step.
package stream_packer_pkg;

    // Default wide stream width, which is also the FIFO DATA_WIDTH.
    localparam int unsigned STREAM_DATA_WIDTH = 32;
    // Default lane (narrow beat) width.
    localparam int unsigned STREAM_LANE_WIDTH = 8;
    // Default number of lanes per wide word.
    localparam int unsigned STREAM_RATIO      = STREAM_DATA_WIDTH / STREAM_LANE_WIDTH;

    // True when v is a non-zero power of two.
    function automatic bit isPow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// Single-entry valid/ready register slice with a generic payload.
// Ports:
//   clkIn, rstNIn        clock, asynchronous active-low reset
//   inValidIn            upstream word valid
//   inReadyOut           slice can take a word (empty or draining), combinational
//   inPayloadIn          upstream payload
//   outValidOut          registered word valid
//   outReadyIn           downstream accepts the word
//   outPayloadOut        registered payload, held stable while stalled
module stream_reg_slice #(
    parameter int unsigned PAYLOAD_WIDTH = 32
) (
    input  logic                     clkIn,
    input  logic                     rstNIn,
    input  logic                     inValidIn,
    output logic                     inReadyOut,
    input  logic [PAYLOAD_WIDTH-1:0] inPayloadIn,
    output logic                     outValidOut,
    input  logic                     outReadyIn,
    output logic [PAYLOAD_WIDTH-1:0] outPayloadOut
);

    logic                     validR;
    logic [PAYLOAD_WIDTH-1:0] payloadR;

    // A word can enter when the register is empty or leaving on this edge.
    assign inReadyOut = !validR || outReadyIn;

    // Load takes priority over drain, so back-to-back words keep valid high.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            validR   <= 1'b0;
            payloadR <= '0;
        end else if (inValidIn && inReadyOut) begin
            validR   <= 1'b1;
            payloadR <= inPayloadIn;
        end else if (outReadyIn) begin
            validR   <= 1'b0;
        end
    end

    assign outValidOut   = validR;
    assign outPayloadOut = payloadR;

endmodule

// File: rtl/stream_packer.sv
// Width upsizer: packs RATIO narrow beats into one wide word, with per-lane
// keep bits and a last flag, for the FIFO write port. A packet end or a flush
// emits a zero-filled partial word.
// Ports:
//   clkIn, rstNIn        clock, asynchronous active-low reset
//   wrDataIn             narrow input beat
//   wrValidIn            input beat valid
//   wrLastIn             beat closes a packet
//   wrReadyOut           beat accepted when wrValidIn & wrReadyOut (combinational)
//   flushIn              request to emit the partially filled word
//   rdDataOut            packed word, lane 0 in the low bits
//   rdKeepOut            bit i set when lane i holds data
//   rdLastOut            word closes a packet
//   rdValidOut           output word valid
//   rdReadyIn            downstream accepts the word
module stream_packer
    import stream_packer_pkg::*;
#(
    parameter int unsigned IN_WIDTH = STREAM_LANE_WIDTH,
    parameter int unsigned RATIO    = STREAM_RATIO
) (
    input  logic                      clkIn,
    input  logic                      rstNIn,
    input  logic [IN_WIDTH-1:0]       wrDataIn,
    input  logic                      wrValidIn,
    input  logic                      wrLastIn,
    output logic                      wrReadyOut,
    input  logic                      flushIn,
    output logic [IN_WIDTH*RATIO-1:0] rdDataOut,
    output logic [RATIO-1:0]          rdKeepOut,
    output logic                      rdLastOut,
    output logic                      rdValidOut,
    input  logic                      rdReadyIn
);

    localparam int unsigned OUT_WIDTH     = IN_WIDTH * RATIO;
    localparam int unsigned LANE_WIDTH    = $clog2(RATIO);
    localparam int unsigned PAYLOAD_WIDTH = 1 + RATIO + OUT_WIDTH;

    // Lane arithmetic relies on the counter wrapping naturally at RATIO.
    if (RATIO < 2 || !isPow2(RATIO)) begin : gBadRatio
        $error("stream_packer: RATIO must be a power of two and at least 2");
    end

    logic [OUT_WIDTH-1:0]     accR;
    logic [RATIO-1:0]         keepAccR;
    logic [LANE_WIDTH-1:0]    laneR;

    logic                     sliceReady;
    logic                     wrEn;
    logic                     complete;
    logic                     flushGo;
    logic                     loadEn;
    logic [OUT_WIDTH-1:0]     mergedData;
    logic [RATIO-1:0]         mergedKeep;
    logic [PAYLOAD_WIDTH-1:0] loadPayload;
    logic [PAYLOAD_WIDTH-1:0] outPayload;

    assign wrReadyOut = sliceReady;
    assign wrEn       = wrValidIn && sliceReady;
    assign complete   = wrEn && ((laneR == LANE_WIDTH'(RATIO - 1)) || wrLastIn);

    // Accumulator as it would look with the current beat written in.
    always_comb begin
        mergedData = accR;
        mergedKeep = keepAccR;
        for (int i = 0; i < RATIO; i++) begin
            if (wrEn && (laneR == LANE_WIDTH'(i))) begin
                mergedData[i*IN_WIDTH +: IN_WIDTH] = wrDataIn;
                mergedKeep[i]                      = 1'b1;
            end
        end
    end

    // A completion on the same edge wins; a flush of nothing emits nothing.
    assign flushGo     = flushIn && sliceReady && !complete && (mergedKeep != '0);
    assign loadEn      = complete || flushGo;
    assign loadPayload = {complete && wrLastIn, mergedKeep, mergedData};

    // Accumulator and lane counter; cleared whenever a word leaves for the output.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            accR     <= '0;
            keepAccR <= '0;
            laneR    <= '0;
        end else if (loadEn) begin
            accR     <= '0;
            keepAccR <= '0;
            laneR    <= '0;
        end else if (wrEn) begin
            accR     <= mergedData;
            keepAccR <= mergedKeep;
            laneR    <= laneR + LANE_WIDTH'(1);
        end
    end

    stream_reg_slice #(
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
    ) uOutReg (
        .clkIn         (clkIn),
        .rstNIn        (rstNIn),
        .inValidIn     (loadEn),
        .inReadyOut    (sliceReady),
        .inPayloadIn   (loadPayload),
        .outValidOut   (rdValidOut),
        .outReadyIn    (rdReadyIn),
        .outPayloadOut (outPayload)
    );

    assign rdDataOut = outPayload[OUT_WIDTH-1:0];
    assign rdKeepOut = outPayload[OUT_WIDTH +: RATIO];
    assign rdLastOut = outPayload[PAYLOAD_WIDTH-1];

endmodule
